// File: rtl/hex_display_engine_pkg.sv
// Shared types, segment glyphs and helpers for the hex display engine.
// Segment codes are active-low, bit0 = segment a ... bit6 = segment g.
package hex_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_MSG   = 2'd1,
      MODE_VALUE = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_t;

   typedef enum logic [2:0] {
      MSG_BLANK = 3'd0,
      MSG_PLAY  = 3'd1,
      MSG_SOON  = 3'd2,
      MSG_ERR   = 3'd3
   } msg_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_ENC  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_P    = 7'b0001100;
   localparam logic [6:0] SEG_L    = 7'b1000111;
   localparam logic [6:0] SEG_A    = 7'b0001000;
   localparam logic [6:0] SEG_Y    = 7'b0010001;
   localparam logic [6:0] SEG_N    = 7'b0101011;
   localparam logic [6:0] SEG_E    = 7'b0000110;
   localparam logic [6:0] SEG_R    = 7'b0101111;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
      case (d)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_OFF;
      endcase
   endfunction

   // idx 0 is HEX0 (rightmost); glyph positions above 5 are always dark.
   function automatic logic [6:0] msg_glyph(input msg_t m, input int idx);
      logic [6:0] g;
      g = SEG_OFF;
      case (m)
         MSG_PLAY: case (idx)
            3: g = SEG_P;
            2: g = SEG_L;
            1: g = SEG_A;
            0: g = SEG_Y;
            default: g = SEG_OFF;
         endcase
         MSG_SOON: case (idx)
            5: g = SEG_2;
            3: g = SEG_5;
            2: g = SEG_0;
            1: g = SEG_0;
            0: g = SEG_N;
            default: g = SEG_OFF;
         endcase
         MSG_ERR: case (idx)
            3: g = SEG_E;
            2: g = SEG_R;
            1: g = SEG_R;
            default: g = SEG_OFF;
         endcase
         default: g = SEG_OFF;
      endcase
      return g;
   endfunction

   function automatic longint unsigned pow10(input int n);
      longint unsigned r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/hex_display_engine_if.sv
// Command channel of the hex display engine.
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready; payload is only looked at then.
interface hex_display_engine_if #(parameter int VALUE_W = 20);
   import hex_pkg::*;

   logic               cmd_valid;
   logic               cmd_ready;
   mode_t              cmd_mode;
   msg_t               cmd_msg;
   logic [VALUE_W-1:0] cmd_value;

   modport master (output cmd_valid, cmd_mode, cmd_msg, cmd_value, input cmd_ready);
   modport slave  (input cmd_valid, cmd_mode, cmd_msg, cmd_value, output cmd_ready);
endinterface

// File: rtl/hex_display_engine_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle, BIN_W steps per conversion.
// done pulses for one cycle once bcd holds the final result; bcd is stable until the next start.
module bin2bcd_seq #(
   parameter int BIN_W = 20,
   parameter int BCD_W = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);
   localparam int CNT_W = $clog2(BIN_W + 1);

   logic [BIN_W-1:0]       sh_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [BCD_W-1:0]       adj;
   logic [BCD_W+BIN_W-1:0] nxt;

   always_comb begin
      adj = bcd;
      for (int i = 0; i < BCD_W / 4; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      nxt = {adj, sh_q} << 1;
   end

   assign busy = (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         sh_q  <= '0;
         bcd   <= '0;
         done  <= 1'b0;
      end else if (start) begin
         cnt_q <= CNT_W'(BIN_W);
         sh_q  <= bin;
         bcd   <= '0;
         done  <= 1'b0;
      end else if (busy) begin
         bcd   <= nxt[BCD_W+BIN_W-1 -: BCD_W];
         sh_q  <= nxt[BIN_W-1:0];
         cnt_q <= cnt_q - CNT_W'(1);
         done  <= (cnt_q == CNT_W'(1));
      end else begin
         done  <= 1'b0;
      end
   end
endmodule

// File: rtl/hex_display_engine.sv
// Clocked driver for NUM_DIGITS active-low 7-segment digits: blank, canned message or decimal value.
// Optional macro HEX_BLINK_EN adds the blink input and the blink phase counter.
module hex_display_engine
   import hex_pkg::*;
#(
   parameter int NUM_DIGITS   = 6,
   parameter int VALUE_W      = 20,
   parameter int BLINK_CYCLES = 25000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   hex_display_engine_if.slave     cmd,
   output logic                    busy,
   output logic [7*NUM_DIGITS-1:0] hex_out,
`ifdef HEX_BLINK_EN
   input  logic                    blink,
`endif
   output state_t                  dbg_state
);
   localparam int              BCD_W   = 4*NUM_DIGITS + 4;
   localparam longint unsigned MAX_VAL = pow10(NUM_DIGITS) - 1;

   if (BLINK_CYCLES < 1) begin : g_bad_blink
      $error("BLINK_CYCLES must be at least 1");
   end

   state_t                  state_q;
   logic                    ready_q, ovf_q, ovf;
   logic [7*NUM_DIGITS-1:0] content_q, msg_seg, val_seg;
   logic                    accept, start, conv_busy, conv_done, lit;
   logic [BCD_W-1:0]        bcd;
   logic [3:0]              dig;

   assign accept        = cmd.cmd_valid && ready_q;
   assign start         = accept && (cmd.cmd_mode == MODE_VALUE);
   assign cmd.cmd_ready = ready_q;
   assign busy          = !ready_q;
   assign dbg_state     = state_q;

   bin2bcd_seq #(.BIN_W(VALUE_W), .BCD_W(BCD_W)) u_bcd (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(cmd.cmd_value),
      .busy(conv_busy), .done(conv_done), .bcd(bcd)
   );

   // The spare top nibble can only be nonzero when the value already overflowed.
   assign ovf = ovf_q || (bcd[BCD_W-1 -: 4] != 4'd0);

   always_comb begin
      msg_seg = '1;
      val_seg = '1;
      lit     = 1'b0;
      dig     = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) msg_seg[7*i +: 7] = msg_glyph(cmd.cmd_msg, i);
      // Scan from the top so every digit below the first nonzero one stays lit.
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         dig = bcd[4*i +: 4];
         if (dig != 4'd0 || i == 0) lit = 1'b1;
         val_seg[7*i +: 7] = ovf ? SEG_DASH : (lit ? digit_to_seg(dig) : SEG_OFF);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         ovf_q     <= 1'b0;
         content_q <= '1;
      end else begin
         case (state_q)
            ST_IDLE: if (accept) begin
               case (cmd.cmd_mode)
                  MODE_MSG:   content_q <= msg_seg;
                  MODE_VALUE: begin
                     state_q <= ST_CONV;
                     ready_q <= 1'b0;
                     ovf_q   <= (64'(cmd.cmd_value) > MAX_VAL);
                  end
                  default:    content_q <= '1;
               endcase
            end
            ST_CONV: if (conv_done) begin
               state_q <= ST_ENC;
            end else if (!conv_busy) begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
            ST_ENC: begin
               content_q <= val_seg;
               state_q   <= ST_IDLE;
               ready_q   <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

`ifdef HEX_BLINK_EN
   localparam int BC_W = $clog2(BLINK_CYCLES) + 1;

   logic [BC_W-1:0] blink_cnt_q;
   logic            vis_q;

   always_ff @(posedge clk) begin
      if (!rst_n || !blink) begin
         blink_cnt_q <= '0;
         vis_q       <= 1'b1;
      end else if (blink_cnt_q == BC_W'(BLINK_CYCLES - 1)) begin
         blink_cnt_q <= '0;
         vis_q       <= !vis_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BC_W'(1);
      end
   end

   assign hex_out = vis_q ? content_q : '1;
`else
   assign hex_out = content_q;
`endif

endmodule

// File: tb/tb_hex_display_engine.sv
// Directed self-checking bench for hex_display_engine (NUM_DIGITS=6, VALUE_W=20, BLINK_CYCLES=4).
module tb_hex_display_engine;
  import hex_pkg::*;

  localparam int N  = 6;
  localparam int W  = 20;
  localparam int BC = 4;
  localparam int HW = 7 * N;

  // Hand-written glyphs, active-low, bit0 = segment a
  localparam logic [6:0] G_OFF = 7'b1111111;
  localparam logic [6:0] G_DSH = 7'b0111111;
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000, G9 = 7'b0010000;
  localparam logic [6:0] GP = 7'b0001100, GL = 7'b1000111, GA = 7'b0001000;
  localparam logic [6:0] GY = 7'b0010001, GN = 7'b0101011, GE = 7'b0000110;
  localparam logic [6:0] GR = 7'b0101111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          busy;
  logic          blink = 1'b0;
  logic [HW-1:0] hex_out;
  state_t        dbg_state;

  hex_display_engine_if #(.VALUE_W(W)) cmd_if ();

  hex_display_engine #(.NUM_DIGITS(N), .VALUE_W(W), .BLINK_CYCLES(BC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd(cmd_if),
    .busy(busy),
    .hex_out(hex_out),
`ifdef HEX_BLINK_EN
    .blink(blink),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] six(input logic [6:0] h5, h4, h3, h2, h1, h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  localparam logic [HW-1:0] DARK = '1;

  task automatic send(input mode_t m, input msg_t g, input logic [W-1:0] v);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = m;
    cmd_if.cmd_msg   = g;
    cmd_if.cmd_value = v;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Sends a value and follows it until the engine is ready again.
  task automatic run_value(input string tag, input logic [W-1:0] v, input logic [HW-1:0] exp);
    logic [HW-1:0] old;
    int            n;
    bit            held;
    @(negedge clk);
    old  = hex_out;
    held = 1'b1;
    n    = 0;
    send(MODE_VALUE, MSG_BLANK, v);
    while (busy && n < 100) begin
      if (hex_out !== old) held = 1'b0;
      n++;
      @(posedge clk);
      #1;
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(W + 2));
    check({tag, "_held"}, 64'(held), 64'd1);
    check({tag, "_result"}, 64'(hex_out), 64'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HW-1:0] vis_exp;
    int            n;
    bit            stayed;
    bit            ready_ok;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = MODE_OFF;
    cmd_if.cmd_msg   = MSG_BLANK;
    cmd_if.cmd_value = '0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 64'(hex_out), 64'(DARK));
    check("rst_ready", 64'(cmd_if.cmd_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n  = 1'b1;
    stayed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hex_out !== DARK || cmd_if.cmd_ready !== 1'b1) stayed = 1'b0;
    end
    check("idle_dark", 64'(stayed), 64'd1);

    // Messages, including back-to-back commands on consecutive edges
    send(MODE_MSG, MSG_PLAY, '0);
    check("msg_play", 64'(hex_out), 64'(six(G_OFF, G_OFF, GP, GL, GA, GY)));
    check("msg_play_ready", 64'(cmd_if.cmd_ready), 64'd1);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = MODE_MSG;
    cmd_if.cmd_msg   = MSG_SOON;
    @(posedge clk);
    #1;
    check("msg_soon", 64'(hex_out), 64'(six(G2, G_OFF, G5, G0, G0, GN)));
    cmd_if.cmd_msg = MSG_ERR;
    @(posedge clk);
    #1;
    check("msg_err_b2b", 64'(hex_out), 64'(six(G_OFF, G_OFF, GE, GR, GR, G_OFF)));
    cmd_if.cmd_mode = MODE_RSVD;
    @(posedge clk);
    #1;
    check("mode3_dark", 64'(hex_out), 64'(DARK));
    cmd_if.cmd_valid = 1'b0;
    send(MODE_MSG, MSG_ERR, '0);
    send(MODE_OFF, MSG_PLAY, '0);
    check("mode_off", 64'(hex_out), 64'(DARK));
    send(MODE_MSG, MSG_ERR, '0);

    // Values, leading-zero blanking and overflow
    run_value("v347", 20'd347, six(G_OFF, G_OFF, G_OFF, G3, G4, G7));
    run_value("v0", 20'd0, six(G_OFF, G_OFF, G_OFF, G_OFF, G_OFF, G0));
    run_value("v100005", 20'd100005, six(G1, G0, G0, G0, G0, G5));
    run_value("v1000000", 20'd1000000, six(G_DSH, G_DSH, G_DSH, G_DSH, G_DSH, G_DSH));
    run_value("v999999", 20'd999999, six(G9, G9, G9, G9, G9, G9));
    run_value("vmax", 20'hFFFFF, six(G_DSH, G_DSH, G_DSH, G_DSH, G_DSH, G_DSH));

    // cmd_valid held with a new value during conversion
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = MODE_VALUE;
    cmd_if.cmd_value = 20'd512;
    @(posedge clk);
    #1;
    cmd_if.cmd_value = 20'd88;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    cmd_if.cmd_valid = 1'b0;
    check("hold_busy_cycles", 64'(n), 64'(W + 2));
    check("hold_first_wins", 64'(hex_out), 64'(six(G_OFF, G_OFF, G_OFF, G5, G1, G2)));
    @(posedge clk);
    #1;
    check("hold_no_second", 64'(dbg_state), 64'(ST_IDLE));

    // Reset in the middle of a conversion
    send(MODE_VALUE, MSG_BLANK, 20'd123456);
    repeat (5) @(posedge clk);
    #1;
    check("mid_conv_state", 64'(dbg_state), 64'(ST_CONV));
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_hex", 64'(hex_out), 64'(DARK));
    check("mid_rst_ready", 64'(cmd_if.cmd_ready), 64'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    stayed = 1'b1;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (hex_out !== DARK) stayed = 1'b0;
    end
    check("mid_rst_no_partial", 64'(stayed), 64'd1);

`ifdef HEX_BLINK_EN
    send(MODE_MSG, MSG_SOON, '0);
    vis_exp = six(G2, G_OFF, G5, G0, G0, GN);
    @(negedge clk);
    blink    = 1'b1;
    ready_ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("blink_k%0d", k), 64'(hex_out), ((k / 4) % 2 == 0) ? 64'(vis_exp) : 64'(DARK));
      if (cmd_if.cmd_ready !== 1'b1) ready_ok = 1'b0;
      @(negedge clk);
    end
    check("blink_ready", 64'(ready_ok), 64'd1);
    repeat (4) @(negedge clk);
    check("blink_dark_phase", 64'(hex_out), 64'(DARK));
    blink = 1'b0;
    @(posedge clk);
    #1;
    check("blink_off_visible", 64'(hex_out), 64'(vis_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
